// File: rtl/toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, opcode field values and the
// fetch-front-end state encoding.
package toy_pkg;

  localparam int TOY_AW = 30;
  localparam int TOY_DW = 32;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_ST   = 5'd20;
  localparam logic [4:0] OP_LDR  = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/toy_ifq_fifo.sv
// DEPTH-entry circular buffer holding {instruction, pc} pairs for the fetch
// queue; flush empties it in one cycle and wins over push/pop.
module toy_ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic          pop_eff, full;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_eff = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)    tail <= tail + PW'(1);
      if (pop_eff) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  // NOTE: storage is deliberately not reset; count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_data;
  end

  // Zero when empty so the consumer never sees stale contents.
  assign head_data = empty ? '0 : mem[head];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/toy_ifetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order
// queue, redirect flush with in-flight drop. Optional: TOY_IFQ_BYPASS_EN.
module toy_ifetch_queue
  import toy_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = TOY_AW,
  parameter int            DW       = TOY_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HALT,
  input  logic          REDIR,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          MREQ,
  output logic [AW-1:0] MADDR,
  input  logic          MGNT,
  input  logic          MRVALID,
  input  logic [DW-1:0] MRDATA,
  output logic          INSTR_VALID,
  output logic [DW-1:0] INSTR,
  output logic [AW-1:0] INSTR_PC,
  input  logic          INSTR_READY
);

  localparam int CW = $clog2(DEPTH+1);
  typedef logic [CW-1:0] cnt_t;

  state_t           state;
  logic [AW-1:0]    fpc, rpc;
  cnt_t             inflight, drop, count;
  logic             empty, issue, resp_keep, push, pop;
  logic [DW+AW-1:0] head_data;
  logic [CW:0]      credit_used;

  // Queued plus outstanding fetches may never exceed DEPTH, so a response
  // always finds a free slot.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign MREQ        = (state == S_RUN) && !REDIR && (credit_used < (CW+1)'(DEPTH));
  assign MADDR       = fpc;
  assign issue       = MREQ && MGNT;
  assign resp_keep   = MRVALID && !REDIR && (drop == '0);
  assign pop         = !empty && INSTR_READY && !REDIR;

`ifdef TOY_IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = empty && resp_keep;
  assign push        = resp_keep && !(bypass && INSTR_READY);
  assign INSTR_VALID = !empty || bypass;
  assign INSTR       = bypass ? MRDATA : head_data[DW+AW-1:AW];
  assign INSTR_PC    = bypass ? rpc    : head_data[AW-1:0];
`else
  assign push        = resp_keep;
  assign INSTR_VALID = !empty;
  assign INSTR       = head_data[DW+AW-1:AW];
  assign INSTR_PC    = head_data[AW-1:0];
`endif

  toy_ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + AW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .flush     (REDIR),
    .push      (push),
    .push_data ({MRDATA, rpc}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .empty     (empty)
  );

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, exactly as the hardware does.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_BOOT;
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      case (state)
        S_BOOT:  state <= HALT ? S_HALT : S_RUN;
        S_RUN:   if (HALT)  state <= S_HALT;
        S_HALT:  if (!HALT) state <= S_RUN;
        default: state <= S_BOOT;
      endcase

      inflight <= inflight + cnt_t'(issue) - cnt_t'(MRVALID);

      if (REDIR) begin
        // Everything still outstanding after this edge belongs to the old path.
        fpc  <= REDIR_ADDR;
        rpc  <= REDIR_ADDR;
        drop <= inflight - cnt_t'(MRVALID);
      end else begin
        if (issue) fpc <= fpc + AW'(1);
        if (MRVALID) begin
          if (drop != '0) drop <= drop - cnt_t'(1);
          else            rpc  <= rpc + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_toy_ifetch_queue.sv
// Directed self-checking bench for toy_ifetch_queue with an in-order memory
// responder; expectations adapt when TOY_IFQ_BYPASS_EN is defined.
module tb_toy_ifetch_queue;

`ifdef TOY_IFQ_BYPASS_EN
  localparam int FIRST_VALID = 2;
  localparam bit BYP = 1'b1;
`else
  localparam int FIRST_VALID = 3;
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, HALT, REDIR, MGNT, MRVALID, INSTR_READY;
  logic [29:0] REDIR_ADDR;
  logic [31:0] MRDATA;
  logic        MREQ, INSTR_VALID;
  logic [29:0] MADDR, INSTR_PC;
  logic [31:0] INSTR;

  toy_ifetch_queue dut (
    .CLK         (CLK),
    .RST         (RST),
    .HALT        (HALT),
    .REDIR       (REDIR),
    .REDIR_ADDR  (REDIR_ADDR),
    .MREQ        (MREQ),
    .MADDR       (MADDR),
    .MGNT        (MGNT),
    .MRVALID     (MRVALID),
    .MRDATA      (MRDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_READY (INSTR_READY)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          ngrant;
  logic [29:0] pend[$];
  logic [29:0] gaddr_q[$];
  logic [29:0] deliv_pc[$];
  logic [31:0] deliv_instr[$];
  logic        resp_en, ovr_en;
  logic [31:0] ovr_data;

  typedef struct {
    logic        mgnt;
    logic        ready;
    logic        mreq;
    logic [29:0] maddr;
    logic        ivalid;
    logic [29:0] ipc;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present this cycle's memory response and let combinational outputs settle.
  task automatic prep();
    if (resp_en && pend.size() > 0) begin
      MRVALID = 1'b1;
      MRDATA  = ovr_en ? ovr_data : mem_word(pend[0]);
    end else begin
      MRVALID = 1'b0;
      MRDATA  = '0;
    end
    #1;
  endtask

  task automatic clk_edge();
    logic g, rv;
    logic [29:0] ga;
    g  = MREQ && MGNT;
    ga = MADDR;
    rv = MRVALID;
    if (g) begin
      ngrant++;
      gaddr_q.push_back(ga);
    end
    if (INSTR_VALID && INSTR_READY && !REDIR) begin
      deliv_pc.push_back(INSTR_PC);
      deliv_instr.push_back(INSTR);
    end
    @(posedge CLK);
    if (rv) void'(pend.pop_front());
    if (g) pend.push_back(ga);
    @(negedge CLK);
  endtask

  task automatic step();
    prep();
    clk_edge();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    HALT = 1'b0; REDIR = 1'b0; REDIR_ADDR = '0; MGNT = 1'b0;
    MRVALID = 1'b0; MRDATA = '0; INSTR_READY = 1'b0;
    resp_en = 1'b0; ovr_en = 1'b0; ovr_data = '0;
    pend.delete(); gaddr_q.delete(); deliv_pc.delete(); deliv_instr.delete();
    ngrant = 0;
    @(negedge CLK);
    #1;
    check("rst_mreq", 64'(MREQ), 64'd0);
    check("rst_maddr", 64'(MADDR), 64'd0);
    check("rst_ivalid", 64'(INSTR_VALID), 64'd0);
    check("rst_instr", 64'(INSTR), 64'd0);
    check("rst_ipc", 64'(INSTR_PC), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    #1;

    // Streaming from reset: latency-1 memory, always-ready core.
    for (int c = 0; c < 10; c++) begin
      vecs[c].mgnt   = 1'b1;
      vecs[c].ready  = 1'b1;
      vecs[c].mreq   = (c >= 1);
      vecs[c].maddr  = (c >= 1) ? 30'(c - 1) : 30'd0;
      vecs[c].ivalid = (c >= FIRST_VALID);
      vecs[c].ipc    = (c >= FIRST_VALID) ? 30'(c - FIRST_VALID) : 30'd0;
    end
    do_reset();
    resp_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      MGNT        = vecs[c].mgnt;
      INSTR_READY = vecs[c].ready;
      prep();
      check($sformatf("s1_mreq[%0d]", c), 64'(MREQ), 64'(vecs[c].mreq));
      if (vecs[c].mreq) check($sformatf("s1_maddr[%0d]", c), 64'(MADDR), 64'(vecs[c].maddr));
      check($sformatf("s1_ivalid[%0d]", c), 64'(INSTR_VALID), 64'(vecs[c].ivalid));
      if (vecs[c].ivalid) begin
        check($sformatf("s1_ipc[%0d]", c), 64'(INSTR_PC), 64'(vecs[c].ipc));
        check($sformatf("s1_instr[%0d]", c), 64'(INSTR), 64'(mem_word(vecs[c].ipc)));
      end
      clk_edge();
    end

    // Back-pressure: credit cap of 4, then one pop frees exactly one credit.
    do_reset();
    MGNT = 1'b1; resp_en = 1'b1; INSTR_READY = 1'b0;
    repeat (12) step();
    check("bp_grants", 64'(ngrant), 64'd4);
    prep();
    check("bp_mreq_full", 64'(MREQ), 64'd0);
    check("bp_head_pc", 64'(INSTR_PC), 64'd0);
    INSTR_READY = 1'b1;
    prep();
    clk_edge();
    INSTR_READY = 1'b0;
    repeat (6) step();
    check("bp_grants_after_pop", 64'(ngrant), 64'd5);
    check("bp_last_addr", 64'(gaddr_q[gaddr_q.size()-1]), 64'd4);
    prep();
    check("bp_head_pc2", 64'(INSTR_PC), 64'd1);
    check("bp_mreq_full2", 64'(MREQ), 64'd0);
    #2 RST = 1'b1;
    #1;
    check("midrst_ivalid", 64'(INSTR_VALID), 64'd0);
    check("midrst_maddr", 64'(MADDR), 64'd0);
    check("midrst_instr", 64'(INSTR), 64'd0);

    // Redirect with 3 in flight, one returning in the redirect cycle itself.
    do_reset();
    MGNT = 1'b1; INSTR_READY = 1'b1;
    for (int i = 0; i < 10 && ngrant < 3; i++) step();
    check("rd_grants", 64'(ngrant), 64'd3);
    MGNT = 1'b0;
    REDIR = 1'b1; REDIR_ADDR = 30'h100; resp_en = 1'b1;
    deliv_pc.delete(); deliv_instr.delete();
    prep();
    check("rd_mreq_in_redir", 64'(MREQ), 64'd0);
    clk_edge();
    REDIR = 1'b0; MGNT = 1'b1;
    prep();
    check("rd_mreq_after", 64'(MREQ), 64'd1);
    check("rd_maddr_after", 64'(MADDR), 64'h100);
    clk_edge();
    for (int i = 0; i < 20 && deliv_pc.size() == 0; i++) step();
    check("rd_delivered", 64'(deliv_pc.size() > 0), 64'd1);
    if (deliv_pc.size() > 0) begin
      check("rd_first_pc", 64'(deliv_pc[0]), 64'h100);
      check("rd_first_instr", 64'(deliv_instr[0]), 64'(mem_word(30'h100)));
    end

    // Address wrap at the top of the word space.
    REDIR = 1'b1; REDIR_ADDR = 30'h3FFF_FFFE;
    gaddr_q.delete();
    step();
    REDIR = 1'b0;
    deliv_pc.delete(); deliv_instr.delete();
    for (int i = 0; i < 30 && deliv_pc.size() < 3; i++) step();
    check("wrap_grants", 64'(gaddr_q.size() >= 3), 64'd1);
    check("wrap_deliv", 64'(deliv_pc.size() >= 3), 64'd1);
    if (gaddr_q.size() >= 3 && deliv_pc.size() >= 3) begin
      check("wrap_maddr0", 64'(gaddr_q[0]), 64'h3FFF_FFFE);
      check("wrap_maddr1", 64'(gaddr_q[1]), 64'h3FFF_FFFF);
      check("wrap_maddr2", 64'(gaddr_q[2]), 64'h0);
      check("wrap_pc2", 64'(deliv_pc[2]), 64'h0);
      check("wrap_instr2", 64'(deliv_instr[2]), 64'(mem_word(30'h0)));
    end

    // HALT with 2 in flight: both delivered, no issue, then resume at 2.
    do_reset();
    MGNT = 1'b1; INSTR_READY = 1'b1;
    for (int i = 0; i < 10 && ngrant < 2; i++) step();
    check("halt_grants", 64'(ngrant), 64'd2);
    MGNT = 1'b0; HALT = 1'b1;
    step();
    prep();
    check("halt_mreq", 64'(MREQ), 64'd0);
    MGNT = 1'b1; resp_en = 1'b1; ngrant = 0;
    deliv_pc.delete(); deliv_instr.delete();
    repeat (6) step();
    check("halt_no_issue", 64'(ngrant), 64'd0);
    check("halt_deliv_n", 64'(deliv_pc.size()), 64'd2);
    if (deliv_pc.size() == 2) begin
      check("halt_pc0", 64'(deliv_pc[0]), 64'd0);
      check("halt_pc1", 64'(deliv_pc[1]), 64'd1);
    end
    HALT = 1'b0;
    gaddr_q.delete();
    for (int i = 0; i < 10 && gaddr_q.size() == 0; i++) step();
    check("resume_issued", 64'(gaddr_q.size() > 0), 64'd1);
    if (gaddr_q.size() > 0) check("resume_addr", 64'(gaddr_q[0]), 64'd2);

    // Response into an empty queue with the core ready.
    do_reset();
    MGNT = 1'b1; INSTR_READY = 1'b1;
    step();
    step();
    MGNT = 1'b0;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; resp_en = 1'b1;
    prep();
    check("byp_same_cycle_valid", 64'(INSTR_VALID), 64'(BYP));
    if (BYP) check("byp_same_cycle_instr", 64'(INSTR), 64'hDEAD_BEEF);
    clk_edge();
    ovr_en = 1'b0;
    prep();
    check("byp_next_valid", 64'(INSTR_VALID), 64'(!BYP));
    if (!BYP) begin
      check("byp_next_instr", 64'(INSTR), 64'hDEAD_BEEF);
      check("byp_next_pc", 64'(INSTR_PC), 64'd0);
    end
    clk_edge();
    prep();
    check("byp_drained", 64'(INSTR_VALID), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
